// File: rtl/cond_pkg.sv
// Shared condition-field encodings and NZCV bit positions for the conditional-execution stage.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: (Cond, NZCV) -> pass. No state.
module cond_check
  import cond_pkg::*;
#(
  parameter bit NV_EXECUTES = 1'b0
) (
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[N_BIT];
  assign z = Flags[Z_BIT];
  assign c = Flags[C_BIT];
  assign v = Flags[V_BIT];

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = NV_EXECUTES;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds NZCV, gates decoder write requests by the condition,
// and updates flags from the ALU. Gated outputs are zero-latency; flags update on the clock edge.
module cond_logic
  import cond_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET  = 4'b0000,
  parameter bit         NV_EXECUTES = 1'b0
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [3:0] flags_q;
  logic       cond_pass;

  cond_check #(
    .NV_EXECUTES(NV_EXECUTES)
  ) u_cond_check (
    .Cond  (Cond),
    .Flags (flags_q),
    .CondEx(cond_pass)
  );

  // Reset selects a constant so an unknown Cond cannot leak out while in reset.
  assign CondEx   = Reset ? 1'b0 : cond_pass;
  assign PCSrc    = PCS & CondEx;
  assign RegWrite = RegW & CondEx & ~NoWrite;
  assign MemWrite = MemW & CondEx;
  assign Flags    = flags_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      flags_q <= FLAG_RESET;
    end else begin
      if (FlagW[1] & CondEx) begin
        flags_q[N_BIT] <= ALUFlags[N_BIT];
        flags_q[Z_BIT] <= ALUFlags[Z_BIT];
      end
      if (FlagW[0] & CondEx) begin
        flags_q[C_BIT] <= ALUFlags[C_BIT];
        flags_q[V_BIT] <= ALUFlags[V_BIT];
      end
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// Bench for cond_logic: directed vector table, full Cond x Flags sweep, then random traffic vs a model.
module tb_cond_logic;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;
  logic       PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;

  int total = 0;
  int bad   = 0;

  logic [3:0] model_flags;

  cond_logic dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .Cond    (Cond),
    .ALUFlags(ALUFlags),
    .FlagW   (FlagW),
    .PCS     (PCS),
    .RegW    (RegW),
    .MemW    (MemW),
    .NoWrite (NoWrite),
    .PCSrc   (PCSrc),
    .RegWrite(RegWrite),
    .MemWrite(MemWrite),
    .CondEx  (CondEx),
    .Flags   (Flags)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] fw;
    logic       pcs, regw, memw, nw;
    logic [3:0] exp_out;   // {PCSrc, RegWrite, MemWrite, CondEx}
    logic [3:0] exp_flags; // Flags seen during this cycle, before its edge
  } vec_t;

  vec_t vecs[19];

  // Conditions come in complementary pairs: c[3:1] picks a base predicate, c[0] inverts it.
  function automatic bit model_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic vec_t mk(input logic rst, input logic [3:0] cond, input logic [3:0] alu,
                              input logic [1:0] fw, input logic pcs, input logic regw,
                              input logic memw, input logic nw, input logic [3:0] eo,
                              input logic [3:0] ef);
    vec_t r;
    r.rst = rst; r.cond = cond; r.alu = alu; r.fw = fw;
    r.pcs = pcs; r.regw = regw; r.memw = memw; r.nw = nw;
    r.exp_out = eo; r.exp_flags = ef;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one instruction, check outputs #1 later, advance the model across the edge.
  task automatic step(input vec_t v, input bit use_table, input string tag);
    bit         p;
    logic [3:0] eo;
    Reset = v.rst; Cond = v.cond; ALUFlags = v.alu; FlagW = v.fw;
    PCS = v.pcs; RegW = v.regw; MemW = v.memw; NoWrite = v.nw;
    #1;
    p  = v.rst ? 1'b0 : model_pass(v.cond, model_flags);
    eo = {v.pcs & p, v.regw & p & !v.nw, v.memw & p, p};
    if (use_table) begin
      cmp({tag, "_outs"},  {PCSrc, RegWrite, MemWrite, CondEx}, v.exp_out);
      cmp({tag, "_flags"}, Flags, v.exp_flags);
    end else begin
      cmp({tag, "_outs"},  {PCSrc, RegWrite, MemWrite, CondEx}, eo);
      cmp({tag, "_flags"}, Flags, model_flags);
    end
    @(posedge CLK);
    if (v.rst) model_flags = 4'b0000;
    else begin
      if (v.fw[1] && p) model_flags[3:2] = v.alu[3:2];
      if (v.fw[0] && p) model_flags[1:0] = v.alu[1:0];
    end
    @(negedge CLK);
  endtask

  initial begin
    vec_t rv;
    //            rst cond   alu    fw    pcs  regw memw nw    {P,R,M,C} flags
    vecs[0]  = mk(1, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0, 4'b0000, 4'b0000); // reset beats FlagW
    vecs[1]  = mk(1, 4'bx, 4'hF, 2'b11, 1, 1, 1, 0, 4'b0000, 4'b0000); // unknown Cond in reset
    vecs[2]  = mk(0, 4'hE, 4'h6, 2'b11, 0, 1, 0, 0, 4'b0101, 4'b0000); // SUBS -> Z,C
    vecs[3]  = mk(0, 4'hD, 4'h0, 2'b00, 1, 0, 0, 0, 4'b1001, 4'b0110); // BLE taken
    vecs[4]  = mk(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'b0000, 4'b0110); // reset mid-run
    vecs[5]  = mk(0, 4'hD, 4'h0, 2'b00, 1, 0, 0, 0, 4'b0000, 4'b0000); // BLE not taken
    vecs[6]  = mk(0, 4'hE, 4'h4, 2'b11, 0, 1, 0, 0, 4'b0101, 4'b0000); // SUBS Z=1, no bypass
    vecs[7]  = mk(0, 4'hD, 4'h0, 2'b00, 1, 0, 0, 0, 4'b1001, 4'b0100); // BLE sees Z next cycle
    vecs[8]  = mk(0, 4'h1, 4'h8, 2'b11, 0, 1, 1, 0, 4'b0000, 4'b0100); // NE suppressed
    vecs[9]  = mk(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'b0001, 4'b0100); // flags held
    vecs[10] = mk(0, 4'hE, 4'h2, 2'b11, 0, 0, 0, 0, 4'b0001, 4'b0100);
    vecs[11] = mk(0, 4'hE, 4'hB, 2'b10, 0, 0, 0, 0, 4'b0001, 4'b0010); // NZ only
    vecs[12] = mk(0, 4'hE, 4'h1, 2'b01, 0, 0, 0, 0, 4'b0001, 4'b1010); // CV only
    vecs[13] = mk(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'b0001, 4'b1001);
    vecs[14] = mk(0, 4'hE, 4'h6, 2'b11, 0, 1, 0, 1, 4'b0001, 4'b1001); // CMP: no Rd write
    vecs[15] = mk(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'b0001, 4'b0110); // CMP flags landed
    vecs[16] = mk(0, 4'hF, 4'h0, 2'b00, 1, 1, 1, 0, 4'b0000, 4'b0110); // NV suppressed
    vecs[17] = mk(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'b0000, 4'b0110);
    vecs[18] = mk(0, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0, 4'b0000, 4'b0000); // EQ vs reset flags

    Reset = 1'b1; Cond = 4'hE; ALUFlags = 4'hF; FlagW = 2'b11;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
    model_flags = 4'b0000;
    @(negedge CLK);
    @(posedge CLK);
    @(negedge CLK);

    for (int i = 0; i < 19; i++) step(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Load every flag value through the ALU path, then try every condition against it.
    for (int f = 0; f < 16; f++) begin
      step(mk(0, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0, 4'b0, 4'b0), 1'b0, $sformatf("load%0d", f));
      for (int c = 0; c < 16; c++)
        step(mk(0, 4'(c), 4'(~f), 2'b00, 1, 1, 1, 0, 4'b0, 4'b0), 1'b0,
             $sformatf("sweep_f%0d_c%0d", f, c));
    end

    for (int k = 0; k < 600; k++) begin
      rv = mk(($urandom_range(15) == 0), 4'($urandom), 4'($urandom), 2'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'b0, 4'b0);
      step(rv, 1'b0, $sformatf("rand%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
